ascii_hex_tokenizer: RTL and testbench

- Consumes the raw stdin byte stream that the stdin-reader bench stage produces, one byte per accepted beat.
- Parses whitespace-separated ASCII hex numbers into WIDTH-bit tokens for the interpreter core.
- Emits tokens through a valid/ready handshake and flags malformed tokens.
- Sits directly downstream of the stdin reader and upstream of the execution logic.

---
 rtl/ascii_hex_tokenizer_if.sv | 26 ++
 rtl/ascii_hex_tokenizer.sv | 148 ++++++++++++++
 tb/tb_ascii_hex_tokenizer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascii_hex_tokenizer_if.sv
// Handshake bundle between the stdin byte stream, the tokenizer and the token consumer.
// The tokenizer uses the slave view; the byte source / token sink side uses the master view.
interface ascii_hex_tokenizer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_eof;
  logic             in_ready;
  logic             tok_valid;
  logic [WIDTH-1:0] tok_data;
  logic             tok_err;
  logic             tok_ready;
  logic [15:0]      tok_count;
  logic             done;

  modport master (
    output in_valid, in_data, in_eof, tok_ready,
    input  in_ready, tok_valid, tok_data, tok_err, tok_count, done
  );

  modport slave (
    input  in_valid, in_data, in_eof, tok_ready,
    output in_ready, tok_valid, tok_data, tok_err, tok_count, done
  );
endinterface

// File: rtl/ascii_hex_tokenizer.sv
// Splits a whitespace-delimited ASCII byte stream into WIDTH-bit hex tokens.
// Malformed words (bad characters or too many digits) become error tokens with zero data.
module ascii_hex_tokenizer #(
  parameter int WIDTH      = 32,
  parameter int MAX_DIGITS = 8
) (
  input logic                 CLK,
  input logic                 RST,
  ascii_hex_tokenizer_if.slave bus
);

  if ((WIDTH % 4) != 0 || (MAX_DIGITS * 4) > WIDTH) begin : g_bad_params
    $error("ascii_hex_tokenizer: WIDTH must be a multiple of 4 and hold MAX_DIGITS nibbles");
  end

  localparam int CW = $clog2(MAX_DIGITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_ERRSKIP,
    S_EMIT,
    S_EMIT_LAST,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] tok_data_q, tok_data_d;
  logic             tok_err_q, tok_err_d;
  logic [15:0]      tok_count_q, tok_count_d;

  logic       emitting;
  logic       accept;
  logic       is_digit;
  logic       is_delim;
  logic [3:0] nibble;

  // Byte classification; letters map through their low nibble (A/a = x1 -> 10).
  always_comb begin
    is_digit = 1'b0;
    nibble   = 4'd0;
    if (bus.in_data >= 8'h30 && bus.in_data <= 8'h39) begin
      is_digit = 1'b1;
      nibble   = bus.in_data[3:0];
    end else if ((bus.in_data >= 8'h41 && bus.in_data <= 8'h46) ||
                 (bus.in_data >= 8'h61 && bus.in_data <= 8'h66)) begin
      is_digit = 1'b1;
      nibble   = bus.in_data[3:0] + 4'd9;
    end
    is_delim = (bus.in_data == 8'h20) || (bus.in_data == 8'h09) ||
               (bus.in_data == 8'h0A) || (bus.in_data == 8'h0D);
  end

  assign emitting = (state_q == S_EMIT) || (state_q == S_EMIT_LAST);
  assign accept   = bus.in_valid && !emitting;

  // NOTE: every always_comb target gets its default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    tok_data_d  = tok_data_q;
    tok_err_d   = tok_err_q;
    tok_count_d = tok_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.in_eof) begin
            state_d = S_DONE;
          end else if (is_digit) begin
            acc_d   = WIDTH'(nibble);
            cnt_d   = CW'(1);
            state_d = S_ACCUM;
          end else if (!is_delim) begin
            state_d = S_ERRSKIP;
          end
        end
      end

      S_ACCUM: begin
        if (accept) begin
          if (bus.in_eof || is_delim) begin
            tok_data_d = acc_q;
            tok_err_d  = 1'b0;
            state_d    = bus.in_eof ? S_EMIT_LAST : S_EMIT;
          end else if (is_digit && cnt_q != CW'(MAX_DIGITS)) begin
            acc_d = {acc_q[WIDTH-5:0], nibble};
            cnt_d = cnt_q + 1'b1;
          end else begin
            state_d = S_ERRSKIP;
          end
        end
      end

      S_ERRSKIP: begin
        if (accept && (bus.in_eof || is_delim)) begin
          tok_data_d = '0;
          tok_err_d  = 1'b1;
          state_d    = bus.in_eof ? S_EMIT_LAST : S_EMIT;
        end
      end

      S_EMIT, S_EMIT_LAST: begin
        if (bus.tok_ready) begin
          tok_count_d = tok_count_q + 16'd1;
          acc_d       = '0;
          cnt_d       = '0;
          state_d     = (state_q == S_EMIT_LAST) ? S_DONE : S_IDLE;
        end
      end

      S_DONE: ;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      tok_data_q  <= '0;
      tok_err_q   <= 1'b0;
      tok_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      tok_data_q  <= tok_data_d;
      tok_err_q   <= tok_err_d;
      tok_count_q <= tok_count_d;
    end
  end

  // Token output is unbuffered: input stalls for as long as a token waits.
  assign bus.in_ready  = !emitting;
  assign bus.tok_valid = emitting;
  assign bus.tok_data  = tok_data_q;
  assign bus.tok_err   = tok_err_q;
  assign bus.tok_count = tok_count_q;
  assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_ascii_hex_tokenizer.sv
// Scoreboard bench: a word-level reference model queues expected tokens, a monitor pops
// and compares them on every handshake; directed cases plus randomized byte streams.
module tb_ascii_hex_tokenizer;
  localparam int WIDTH      = 32;
  localparam int MAX_DIGITS = 8;

  typedef struct {
    logic             err;
    logic [WIDTH-1:0] data;
  } tok_t;

  logic CLK;
  logic RST;

  ascii_hex_tokenizer_if #(.WIDTH(WIDTH)) bus ();

  ascii_hex_tokenizer #(
    .WIDTH      (WIDTH),
    .MAX_DIGITS (MAX_DIGITS)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int           total = 0;
  int           bad   = 0;
  tok_t         exp_q[$];
  byte unsigned stim_q[$];
  int           model_n;
  bit           model_pending;
  int           rdy_mode = 1;  // 0 random, 1 always ready, 2 never ready
  bit           stalled  = 0;
  tok_t         held;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: split on whitespace, judge each word as a whole.
  function automatic int hex_val(input byte unsigned c);
    string digits;
    byte unsigned lc;
    digits = "0123456789abcdef";
    lc = (c >= "A" && c <= "Z") ? c + 8'd32 : c;
    for (int k = 0; k < 16; k++) if (digits[k] == lc) return k;
    return -1;
  endfunction

  function automatic bit is_ws(input byte unsigned c);
    return c == 8'h20 || c == 8'h09 || c == 8'h0A || c == 8'h0D;
  endfunction

  task automatic model_push(input int len, input bit ok, input logic [WIDTH-1:0] val);
    tok_t t;
    t.err  = !(ok && len <= MAX_DIGITS);
    t.data = t.err ? '0 : val;
    exp_q.push_back(t);
    model_n++;
  endtask

  task automatic model_stream();
    int               len = 0;
    bit               ok  = 1;
    logic [WIDTH-1:0] val = '0;
    model_n = 0;
    foreach (stim_q[i]) begin
      if (is_ws(stim_q[i])) begin
        if (len > 0) model_push(len, ok, val);
        len = 0; ok = 1; val = '0;
      end else begin
        len++;
        if (hex_val(stim_q[i]) < 0) ok = 0;
        else val = val * 16 + WIDTH'(hex_val(stim_q[i]));
      end
    end
    model_pending = (len > 0);
    if (len > 0) model_push(len, ok, val);
  endtask

  task automatic load_string(input string s);
    stim_q.delete();
    for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
  endtask

  // Called at a falling edge; returns at the falling edge after the beat was accepted.
  task automatic send(input byte unsigned b, input bit eof);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    bus.in_eof   = eof;
    while (!bus.in_ready && waited < 500) begin
      @(negedge CLK);
      waited++;
    end
    if (!bus.in_ready) begin
      check("in_ready_timeout", {63'd0, bus.in_ready}, 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    @(negedge CLK);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int waited = 0;
    while (!bus.done && waited < 500) begin
      @(negedge CLK);
      waited++;
    end
    check("done", {63'd0, bus.done}, 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("tok_count", {48'd0, bus.tok_count}, 64'(model_n));
  endtask

  task automatic do_reset();
    RST          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_eof   = 1'b0;
    bus.in_data  = 8'h00;
    repeat (2) @(negedge CLK);
    exp_q.delete();
    RST = 1'b0;
    check("rst_in_ready",  {63'd0, bus.in_ready},  64'd1);
    check("rst_tok_valid", {63'd0, bus.tok_valid}, 64'd0);
    check("rst_tok_count", {48'd0, bus.tok_count}, 64'd0);
    check("rst_done",      {63'd0, bus.done},      64'd0);
  endtask

  // Full stream from stim_q followed by EOF, with end-of-stream latency checks.
  task automatic run_bytes();
    model_stream();
    foreach (stim_q[i]) send(stim_q[i], 1'b0);
    send(8'h00, 1'b1);
    if (model_pending) begin
      check("eof_latency_valid", {63'd0, bus.tok_valid}, 64'd1);
      if (rdy_mode == 1) begin
        @(negedge CLK);
        check("done_after_last", {63'd0, bus.done}, 64'd1);
      end
    end else begin
      check("done_immediate", {63'd0, bus.done}, 64'd1);
    end
    wait_done();
  endtask

  task automatic run_string(input string s);
    load_string(s);
    run_bytes();
  endtask

  initial begin
    bus.tok_ready = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      case (rdy_mode)
        0:       bus.tok_ready = ($urandom_range(0, 3) != 0);
        1:       bus.tok_ready = 1'b1;
        default: bus.tok_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares each transfer against the scoreboard and checks hold-while-stalled.
  initial begin
    tok_t e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        stalled = 0;
      end else begin
        if (stalled) begin
          check("stall_valid", {63'd0, bus.tok_valid}, 64'd1);
          check("stall_data",  64'(bus.tok_data),      64'(held.data));
          check("stall_err",   {63'd0, bus.tok_err},   {63'd0, held.err});
        end
        stalled = 0;
        if (bus.tok_valid) begin
          check("in_ready_low", {63'd0, bus.in_ready}, 64'd0);
          if (bus.tok_ready) begin
            if (exp_q.size() == 0) begin
              check("spurious_token", {63'd0, bus.tok_valid}, 64'd0);
            end else begin
              e = exp_q.pop_front();
              check("tok_data", 64'(bus.tok_data), 64'(e.data));
              check("tok_err",  {63'd0, bus.tok_err}, {63'd0, e.err});
            end
          end else begin
            stalled   = 1;
            held.data = bus.tok_data;
            held.err  = bus.tok_err;
          end
        end
      end
    end
  end

  initial begin
    RST = 1'b1;
    do_reset();

    rdy_mode = 1;
    run_string("1F 2a\n");
    send("7", 1'b0);
    send(8'h00, 1'b1);
    check("done_hold",      {63'd0, bus.done},      64'd1);
    check("done_no_token",  {63'd0, bus.tok_valid}, 64'd0);
    check("done_count",     {48'd0, bus.tok_count}, 64'd2);

    do_reset();
    run_string("  \t\n7");
    do_reset();
    run_string("123456789 5 ");
    do_reset();
    run_string("12g4 AB ");
    do_reset();
    run_string("");
    do_reset();
    run_string("zz");

    // Backpressure: token held for five cycles, next byte waits.
    do_reset();
    rdy_mode = 2;
    load_string("FF 3");
    model_stream();
    send("F", 1'b0);
    send("F", 1'b0);
    send(" ", 1'b0);
    check("emit_latency", {63'd0, bus.tok_valid}, 64'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = "3";
    bus.in_eof   = 1'b0;
    repeat (5) begin
      @(negedge CLK);
      check("bp_in_ready",  {63'd0, bus.in_ready}, 64'd0);
      check("bp_tok_data",  64'(bus.tok_data),     64'hFF);
    end
    rdy_mode = 1;
    send("3", 1'b0);
    send(8'h00, 1'b1);
    wait_done();

    // Asynchronous reset in the middle of a word.
    do_reset();
    send("A", 1'b0);
    send("B", 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = "C";
    @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    check("mid_rst_valid", {63'd0, bus.tok_valid}, 64'd0);
    check("mid_rst_count", {48'd0, bus.tok_count}, 64'd0);
    check("mid_rst_ready", {63'd0, bus.in_ready},  64'd1);
    bus.in_valid = 1'b0;
    @(negedge CLK);
    exp_q.delete();
    RST = 1'b0;
    run_string("5 ");

    // Randomized streams with random downstream backpressure.
    rdy_mode = 0;
    for (int n = 0; n < 25; n++) begin
      string hexch, wsch, badch;
      int    len;
      int    r;
      hexch = "0123456789abcdefABCDEF";
      wsch  = " \t\n\r";
      badch = "gGxz#.-~@";
      do_reset();
      stim_q.delete();
      len = $urandom_range(0, 40);
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 99);
        if (r < 62)      stim_q.push_back(hexch[$urandom_range(0, 21)]);
        else if (r < 90) stim_q.push_back(wsch[$urandom_range(0, 3)]);
        else             stim_q.push_back(badch[$urandom_range(0, 8)]);
      end
      run_bytes();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
